// File: rtl/mult_div_unit_if.sv
// Request/result bundle for mult_div_unit: operation launch, cancel, direct hi/lo
// writes on the master side; status and result registers on the slave side.
interface mult_div_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         flush;
    logic         hi_we;
    logic         lo_we;
    logic [N-1:0] wd;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, a, b, flush, hi_we, lo_we, wd,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hi_we, lo_we, wd,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with hi/lo result registers (multu, mult, divu, div).
// Latency: N+1 cycles from accepted start to the done pulse; flush/reset abandon silently.
// Backpressure: none queued -- start is dropped while busy, accepted again once IDLE.
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic             clock,
    input  logic             reset,
    mult_div_unit_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [6:0] LAST = 7'(N - 1);

    logic [1:0]   state;
    logic [6:0]   cnt;
    logic         is_div;
    logic         neg_res;
    logic         neg_rem;
    logic         dz;
    logic [N-1:0] a_q;
    logic [N-1:0] acc;
    logic [N-1:0] mq;
    logic [N-1:0] dvs;
    logic [N-1:0] hi_r;
    logic [N-1:0] lo_r;
    logic         done_r;
    logic         dz_r;

    logic [N-1:0] a_mag;
    logic [N-1:0] b_mag;
    logic [N:0]   sum;
    logic [N:0]   shifted;
    logic [N-1:0] acc_nx;
    logic [N-1:0] mq_nx;
    logic [2*N-1:0] prod;
    logic [N-1:0] quo;
    logic [N-1:0] rem;
    logic [N-1:0] hi_nx;
    logic [N-1:0] lo_nx;

    // Iterations run on magnitudes; signs are reapplied in FIX.
    assign a_mag = (bus.op[0] && bus.a[N-1]) ? -bus.a : bus.a;
    assign b_mag = (bus.op[0] && bus.b[N-1]) ? -bus.b : bus.b;

    // acc/mq form one 2N-bit shift register: {partial product, multiplier} for
    // multiply, {partial remainder, dividend->quotient} for divide.
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, dvs};
        shifted = {acc, mq[N-1]};
        acc_nx  = acc;
        mq_nx   = mq;
        if (is_div) begin
            if (shifted >= {1'b0, dvs}) begin
                acc_nx = shifted[N-1:0] - dvs;
                mq_nx  = {mq[N-2:0], 1'b1};
            end else begin
                acc_nx = shifted[N-1:0];
                mq_nx  = {mq[N-2:0], 1'b0};
            end
        end else if (mq[0]) begin
            acc_nx = sum[N:1];
            mq_nx  = {sum[0], mq[N-1:1]};
        end else begin
            acc_nx = {1'b0, acc[N-1:1]};
            mq_nx  = {acc[0], mq[N-1:1]};
        end
    end

    always_comb begin
        prod  = neg_res ? -{acc, mq} : {acc, mq};
        quo   = neg_res ? -mq : mq;
        rem   = neg_rem ? -acc : acc;
        hi_nx = prod[2*N-1:N];
        lo_nx = prod[N-1:0];
        if (is_div) begin
            if (dz) begin
                hi_nx = a_q;
                lo_nx = '1;
            end else begin
                hi_nx = rem;
                lo_nx = quo;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            a_q     <= '0;
            acc     <= '0;
            mq      <= '0;
            dvs     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state   <= RUN;
                            cnt     <= '0;
                            is_div  <= bus.op[1];
                            neg_res <= bus.op[0] & (bus.a[N-1] ^ bus.b[N-1]);
                            neg_rem <= bus.op[0] & bus.a[N-1];
                            dz      <= bus.op[1] & (bus.b == '0);
                            a_q     <= bus.a;
                            acc     <= '0;
                            mq      <= bus.op[1] ? a_mag : b_mag;
                            dvs     <= bus.op[1] ? b_mag : a_mag;
                        end
                    end
                    RUN: begin
                        acc <= acc_nx;
                        mq  <= mq_nx;
                        cnt <= cnt + 7'd1;
                        if (cnt == LAST) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        hi_r   <= hi_nx;
                        lo_r   <= lo_nx;
                        dz_r   <= dz;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
            // Direct writes coexist with a same-edge start; the result lands later.
            if (state == IDLE) begin
                if (bus.hi_we) begin
                    hi_r <= bus.wd;
                end
                if (bus.lo_we) begin
                    lo_r <= bus.wd;
                end
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations scored against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int N = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] exp_hi, exp_lo, pend_hi, pend_lo;
    logic        exp_dz, pend_dz;

    mult_div_unit_if #(.N(N)) bus ();

    mult_div_unit #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero
    // and the remainder follows the dividend, matching the required semantics.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ez = 1'b0;
        eh = '0;
        el = '0;
        case (op)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    ez = 1'b1; eh = a; el = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    el = a / b; eh = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    el = q[31:0]; eh = r[31:0];
                end
            end
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        model(op, a, b, pend_hi, pend_lo, pend_dz);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clock); @(negedge clock);
        bus.start = 1'b0;
        bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
    endtask

    task automatic wait_done(input bit noise, output int cyc, output bit mid_bad);
        cyc = 0;
        mid_bad = 1'b0;
        forever begin
            @(posedge clock); @(negedge clock);
            cyc++;
            if (bus.done === 1'b1) begin
                if (noise) begin
                    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
                end
                return;
            end
            if (bus.busy !== 1'b1 || bus.hi !== exp_hi || bus.lo !== exp_lo) mid_bad = 1'b1;
            if (cyc >= 60) begin
                cyc = -1;
                bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
                return;
            end
            if (noise) begin
                bus.start = ($urandom_range(0, 3) == 0);
                bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
                bus.hi_we = ($urandom_range(0, 3) == 0);
                bus.lo_we = ($urandom_range(0, 3) == 0);
                bus.wd = $urandom;
            end
        end
    endtask

    task automatic finish_op(input string tag, input int lat_exp, input bit noise);
        int cyc;
        bit mid_bad;
        wait_done(noise, cyc, mid_bad);
        check({tag, "_lat"}, 64'(cyc), 64'(lat_exp));
        check({tag, "_mid"}, 64'(mid_bad), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(pend_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(pend_lo));
        check({tag, "_dz"}, 64'(bus.div_zero), 64'(pend_dz));
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
        exp_hi = pend_hi; exp_lo = pend_lo; exp_dz = pend_dz;
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit noise);
        issue(op, a, b);
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        finish_op(tag, N + 1, noise);
    endtask

    initial begin
        int dones;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wd = '0;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;

        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dz", 64'(bus.div_zero), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Direct writes in IDLE
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'h1111_2222;
        @(posedge clock); @(negedge clock);
        bus.hi_we = 1'b0; bus.wd = 32'h3333_4444;
        @(posedge clock); @(negedge clock);
        bus.lo_we = 1'b0;
        check("wr_hi", 64'(bus.hi), 64'h1111_2222);
        check("wr_lo", 64'(bus.lo), 64'h3333_4444);
        exp_hi = 32'h1111_2222; exp_lo = 32'h3333_4444;

        do_op("mult_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
        do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 1'b0);
        do_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("divu_by0", 2'b10, 32'h1234_5678, 32'd0, 1'b0);
        do_op("multu_2x3", 2'b00, 32'd2, 32'd3, 1'b0);
        do_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("div_by0", 2'b11, 32'h8765_4321, 32'd0, 1'b0);

        // Same-edge start and hi write: write visible at once, result later
        bus.hi_we = 1'b1; bus.wd = 32'hCAFE_0001;
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.hi_we = 1'b0;
        check("same_edge_wr", 64'(bus.hi), 64'hCAFE_0001);
        exp_hi = 32'hCAFE_0001;
        finish_op("same_edge_op", N + 1, 1'b0);

        // Flush at cycle 10 with an ignored start earlier in the run
        issue(2'b00, 32'h0001_0000, 32'h0000_0100);
        for (int i = 1; i <= 9; i++) begin
            if (i == 3) begin
                bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd50; bus.b = 32'd5;
            end
            if (i == 4) bus.start = 1'b0;
            @(posedge clock); @(negedge clock);
        end
        check("flush_pre_busy", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(posedge clock); @(negedge clock);
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
            @(posedge clock); @(negedge clock);
        end
        check("flush_no_done", 64'(dones), 64'd0);
        check("flush_hi", 64'(bus.hi), 64'(exp_hi));
        check("flush_lo", 64'(bus.lo), 64'(exp_lo));
        check("flush_dz", 64'(bus.div_zero), 64'(exp_dz));

        // Back-to-back with start held high; hi write while busy is ignored
        issue(2'b11, 32'hFFFF_FF9C, 32'd7);
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'h7FFF_FFFF; bus.b = 32'h8000_0000;
        bus.hi_we = 1'b1; bus.wd = 32'hA5A5_A5A5;
        @(posedge clock); @(negedge clock);
        bus.hi_we = 1'b0;
        check("busy_wr_hi", 64'(bus.hi), 64'(exp_hi));
        finish_op("b2b_first", N, 1'b0);
        @(posedge clock); @(negedge clock);
        bus.start = 1'b0;
        check("b2b_accept", 64'(bus.busy), 64'd1);
        model(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, pend_hi, pend_lo, pend_dz);
        finish_op("b2b_second", N + 1, 1'b0);

        // Asynchronous reset in the middle of a divide
        issue(2'b11, 32'hFFFF_FC18, 32'd7);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); @(negedge clock);
        end
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_dz", 64'(bus.div_zero), 64'd0);
        check("arst_hi", 64'(bus.hi), 64'd0);
        check("arst_lo", 64'(bus.lo), 64'd0);
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        do_op("post_rst", 2'b11, 32'hFFFF_FC18, 32'd7, 1'b0);

        for (int i = 0; i < 25; i++) begin
            do_op($sformatf("rnd%0d", i), 2'($urandom), pick(), pick(), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
